// File: rtl/bitcoin_pkg.sv
// Shared types and widths for the bitcoin nonce scheduler.
// Optional feature macro used by the scheduler: BITCOIN_SCHED_MIN_TRACK_EN.
package bitcoin_pkg;

    localparam int NONCE_W = 32;
    localparam int ADDR_W  = 16;
    localparam int WORD_W  = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts just after the last granted index.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] request,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [IDX_W-1:0] last_idx;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] probe_idx;
    logic             found;
    int               pos;

    always_comb begin
        grant     = '0;
        grant_idx = last_idx;
        probe_idx = '0;
        found     = 1'b0;
        pos       = 0;
        for (int k = 1; k <= N; k++) begin
            pos = int'(last_idx) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            probe_idx = IDX_W'(pos);
            if (!found && request[probe_idx]) begin
                found            = 1'b1;
                grant[probe_idx] = 1'b1;
                grant_idx        = probe_idx;
            end
        end
    end

    // Reset to the top index so the very first search begins at index 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_idx <= IDX_W'(N - 1);
        end else if (advance && found) begin
            last_idx <= grant_idx;
        end
    end

endmodule

// File: rtl/bitcoin_nonce_scheduler.sv
// Dispatches nonces to a bank of SHA-256 cores and serialises their H0 results to memory.
// Define BITCOIN_SCHED_MIN_TRACK_EN to add best_h0/best_nonce minimum tracking.
module bitcoin_nonce_scheduler
    import bitcoin_pkg::*;
#(
    parameter int NUM_CORES  = 4,
    parameter int NUM_NONCES = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [ADDR_W-1:0]            output_addr,
    output logic                         done,
    output logic [NUM_CORES-1:0]         core_start,
    output logic [NUM_CORES*NONCE_W-1:0] core_nonce,
    input  logic [NUM_CORES-1:0]         core_done,
    input  logic [NUM_CORES*WORD_W-1:0]  core_h0,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [WORD_W-1:0]            mem_write_data
`ifdef BITCOIN_SCHED_MIN_TRACK_EN
    ,
    output logic [WORD_W-1:0]            best_h0,
    output logic [NONCE_W-1:0]           best_nonce
`endif
);

    sched_state_t state, state_next;

    logic [ADDR_W-1:0]  base_addr;
    logic [NONCE_W-1:0] next_nonce;
    logic [NONCE_W-1:0] written;
    logic [NUM_CORES-1:0] busy, pending, capture, grant, write_clear;
    logic [NUM_CORES-1:0] dispatch_oh;
    logic               dispatch_found;
    logic               write_en;
    logic               start_accept;
    logic [NONCE_W-1:0] nonce_q [NUM_CORES];
    logic [WORD_W-1:0]  result  [NUM_CORES];
    logic [ADDR_W-1:0]  wr_offset;
    logic [WORD_W-1:0]  wr_data;
`ifdef BITCOIN_SCHED_MIN_TRACK_EN
    logic [NONCE_W-1:0] wr_nonce;
`endif

    assign start_accept = start && (state != RUN);
    assign write_en     = (state == RUN) && (|pending);
    assign write_clear  = write_en ? grant : '0;
    assign capture      = (state == RUN) ? (core_done & busy & ~pending) : '0;
    assign done         = (state == DONE);

    rr_arbiter #(.N(NUM_CORES)) u_rr_arbiter (
        .clk     (clk),
        .reset   (reset),
        .request (pending),
        .advance (write_en),
        .grant   (grant)
    );

    always_comb begin
        dispatch_oh    = '0;
        dispatch_found = 1'b0;
        if ((state == RUN) && (next_nonce < NONCE_W'(NUM_NONCES))) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (!dispatch_found && !busy[i]) begin
                    dispatch_oh[i] = 1'b1;
                    dispatch_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        wr_offset = '0;
        wr_data   = '0;
`ifdef BITCOIN_SCHED_MIN_TRACK_EN
        wr_nonce  = '0;
`endif
        for (int i = 0; i < NUM_CORES; i++) begin
            if (grant[i]) begin
                wr_offset = nonce_q[i][ADDR_W-1:0];
                wr_data   = result[i];
`ifdef BITCOIN_SCHED_MIN_TRACK_EN
                wr_nonce  = nonce_q[i];
`endif
            end
        end
        mem_we         = write_en;
        mem_addr       = write_en ? (base_addr + wr_offset) : '0;
        mem_write_data = write_en ? wr_data : '0;
    end

    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            core_nonce[i*NONCE_W +: NONCE_W] = nonce_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN:  if (write_en && ((written + 1'b1) == NONCE_W'(NUM_NONCES))) state_next = DONE;
            DONE: if (start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    // A write frees its core in the same edge, so the core is dispatchable next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            base_addr  <= '0;
            next_nonce <= '0;
            written    <= '0;
            busy       <= '0;
            pending    <= '0;
            core_start <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                nonce_q[i] <= '0;
                result[i]  <= '0;
            end
        end else begin
            core_start <= dispatch_oh;
            if (start_accept) begin
                base_addr  <= output_addr;
                next_nonce <= '0;
                written    <= '0;
                busy       <= '0;
                pending    <= '0;
            end else if (state == RUN) begin
                if (dispatch_found) next_nonce <= next_nonce + 1'b1;
                if (write_en)       written    <= written + 1'b1;
                busy    <= (busy | dispatch_oh) & ~write_clear;
                pending <= (pending | capture) & ~write_clear;
            end
            for (int i = 0; i < NUM_CORES; i++) begin
                if (dispatch_oh[i]) nonce_q[i] <= next_nonce;
                if (capture[i])     result[i]  <= core_h0[i*WORD_W +: WORD_W];
            end
        end
    end

`ifdef BITCOIN_SCHED_MIN_TRACK_EN
    // Strict compare keeps the earliest-written nonce on ties.
    always_ff @(posedge clk) begin
        if (reset) begin
            best_h0    <= '0;
            best_nonce <= '0;
        end else if (start_accept) begin
            best_h0    <= 32'hFFFF_FFFF;
            best_nonce <= '0;
        end else if (write_en && (wr_data < best_h0)) begin
            best_h0    <= wr_data;
            best_nonce <= wr_nonce;
        end
    end
`endif

endmodule

// File: tb/tb_bitcoin_nonce_scheduler.sv
// Scoreboard bench for bitcoin_nonce_scheduler with behavioural core models.
// Build with BITCOIN_SCHED_MIN_TRACK_EN to also exercise best_h0/best_nonce.
module tb_bitcoin_nonce_scheduler;

    logic         clk, reset, start;
    logic [15:0]  output_addr;
    logic         done, mem_we;
    logic [3:0]   core_start, core_done;
    logic [127:0] core_nonce, core_h0;
    logic [15:0]  mem_addr;
    logic [31:0]  mem_write_data;

    logic         s_done, s_mem_we;
    logic [3:0]   s_core_start, s_core_done;
    logic [127:0] s_core_nonce, s_core_h0;
    logic [15:0]  s_mem_addr;
    logic [31:0]  s_mem_write_data;
`ifdef BITCOIN_SCHED_MIN_TRACK_EN
    logic [31:0]  best_h0, best_nonce, s_best_h0, s_best_nonce;
`endif

    bitcoin_nonce_scheduler #(.NUM_CORES(4), .NUM_NONCES(16)) dut (
        .clk(clk), .reset(reset), .start(start), .output_addr(output_addr),
        .done(done), .core_start(core_start), .core_nonce(core_nonce),
        .core_done(core_done), .core_h0(core_h0), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data)
`ifdef BITCOIN_SCHED_MIN_TRACK_EN
        , .best_h0(best_h0), .best_nonce(best_nonce)
`endif
    );

    bitcoin_nonce_scheduler #(.NUM_CORES(4), .NUM_NONCES(3)) dut_small (
        .clk(clk), .reset(reset), .start(start), .output_addr(16'h0040),
        .done(s_done), .core_start(s_core_start), .core_nonce(s_core_nonce),
        .core_done(s_core_done), .core_h0(s_core_h0), .mem_we(s_mem_we),
        .mem_addr(s_mem_addr), .mem_write_data(s_mem_write_data)
`ifdef BITCOIN_SCHED_MIN_TRACK_EN
        , .best_h0(s_best_h0), .best_nonce(s_best_nonce)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } sb_entry_t;

    sb_entry_t   sb[$];
    int          checks_total = 0;
    int          checks_passed = 0;
    int          lat_base = 70;
    bit          sync_mode = 1'b0;
    bit          special9 = 1'b0;
    logic [3:0]  spur_mask;
    logic [15:0] job_base = 16'h0;
    int          job_writes = 0;
    int          disp_count[16];
    int          cycle_cnt = 0;
    int          wr_cycle[4];
    int          wr_nonce[4];
    int          s_writes = 0;
    bit          s_core3_seen = 1'b0;

    function automatic logic [31:0] h0_of(input logic [31:0] n);
        return (special9 && n == 32'd9) ? 32'h0000_0010 : (n ^ 32'hA5A5_0000);
    endfunction

    function automatic int lat_of(input int i);
        return sync_mode ? lat_base + (3 - i) : lat_base;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks_total++;
        if (got === want) checks_passed++;
        else $display("[TB] FAIL %s: got %h, expected %h", tag, got, want);
    endtask

    // Core models: start pulse seen at an edge, done pulse with H0 a fixed latency later.
    logic        m_done[4];
    logic [31:0] m_h0[4];
    logic [31:0] m_nonce[4];
    int          m_cnt[4];
    logic        sm_done[4];
    logic [31:0] sm_h0[4];
    logic [31:0] sm_nonce[4];
    int          sm_cnt[4];

    for (genvar i = 0; i < 4; i++) begin : g_core
        always @(posedge clk) begin
            m_done[i]  <= 1'b0;
            sm_done[i] <= 1'b0;
            if (reset) begin
                m_cnt[i]  <= 0;
                sm_cnt[i] <= 0;
            end else begin
                if (core_start[i]) begin
                    m_nonce[i] <= core_nonce[i*32 +: 32];
                    m_cnt[i]   <= lat_of(i);
                end else if (m_cnt[i] > 0) begin
                    m_cnt[i] <= m_cnt[i] - 1;
                    if (m_cnt[i] == 1) begin
                        m_done[i] <= 1'b1;
                        m_h0[i]   <= h0_of(m_nonce[i]);
                    end
                end
                if (s_core_start[i]) begin
                    sm_nonce[i] <= s_core_nonce[i*32 +: 32];
                    sm_cnt[i]   <= 4;
                end else if (sm_cnt[i] > 0) begin
                    sm_cnt[i] <= sm_cnt[i] - 1;
                    if (sm_cnt[i] == 1) begin
                        sm_done[i] <= 1'b1;
                        sm_h0[i]   <= h0_of(sm_nonce[i]);
                    end
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            core_done[i]          = m_done[i] | spur_mask[i];
            core_h0[i*32 +: 32]   = spur_mask[i] ? 32'h0 : m_h0[i];
            s_core_done[i]        = sm_done[i];
            s_core_h0[i*32 +: 32] = sm_h0[i];
        end
    end

    // Monitor: push expectations on dispatch, pop and compare on each memory write.
    logic [31:0] mon_n, mon_exp;
    bit          mon_found;
    logic [15:0] mon_off;
    always @(negedge clk) begin
        cycle_cnt++;
        if (!reset) begin
            if (core_start != 4'b0) begin
                checkOutput("start_onehot", 32'($countones(core_start)), 32'd1);
                for (int i = 0; i < 4; i++) begin
                    if (core_start[i]) begin
                        mon_n = core_nonce[i*32 +: 32];
                        if (mon_n < 32'd16) disp_count[mon_n[3:0]]++;
                        sb.push_back({16'(job_base + mon_n[15:0]), h0_of(mon_n)});
                    end
                end
            end
            if (mem_we) begin
                mon_found = 1'b0;
                mon_exp   = 32'h0;
                for (int k = 0; k < sb.size(); k++) begin
                    if (!mon_found && sb[k].addr == mem_addr) begin
                        mon_found = 1'b1;
                        mon_exp   = sb[k].data;
                        sb.delete(k);
                    end
                end
                checkOutput("wr_addr_known", 32'(mon_found), 32'd1);
                if (mon_found) checkOutput("wr_data", mem_write_data, mon_exp);
                if (job_writes < 4) begin
                    wr_cycle[job_writes] = cycle_cnt;
                    wr_nonce[job_writes] = int'(16'(mem_addr - job_base));
                end
                job_writes++;
            end
            if (s_core_start[3]) s_core3_seen = 1'b1;
            if (s_mem_we) begin
                mon_off = s_mem_addr - 16'h0040;
                checkOutput("small_addr_range", 32'(mon_off < 16'd3), 32'd1);
                checkOutput("small_data", s_mem_write_data, 32'(mon_off) ^ 32'hA5A5_0000);
                s_writes++;
            end
        end
    end

    task automatic applyStimulus(input logic [15:0] base, input int lat, input bit sync,
                                 input bit sp9, input bit spur);
        @(negedge clk);
        lat_base   = lat;
        sync_mode  = sync;
        special9   = sp9;
        job_base   = base;
        job_writes = 0;
        foreach (disp_count[i]) disp_count[i] = 0;
        output_addr = base;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (spur) spur_mask = 4'hF;
        @(negedge clk);
        spur_mask = 4'h0;
    endtask

    task automatic waitJob(input string tag);
        int c = 0;
        int ok = 0;
        while (!done && c < 5000) begin
            @(negedge clk);
            c++;
        end
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        checkOutput({tag, "_writes"}, 32'(job_writes), 32'd16);
        checkOutput({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
        foreach (disp_count[i]) if (disp_count[i] == 1) ok++;
        checkOutput({tag, "_disp_once"}, 32'(ok), 32'd16);
    endtask

    initial begin
        int c;
        reset = 1'b1;
        start = 1'b0;
        output_addr = 16'h0;
        spur_mask = 4'h0;
        foreach (disp_count[i]) disp_count[i] = 0;
        repeat (3) @(negedge clk);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_core_start", 32'(core_start), 32'd0);
        checkOutput("rst_core_nonce", 32'(core_nonce != 128'd0), 32'd0);
        reset = 1'b0;

        applyStimulus(16'h0100, 70, 1'b0, 1'b0, 1'b0);
        waitJob("jobA");
        checkOutput("small_done", 32'(s_done), 32'd1);
        checkOutput("small_writes", 32'(s_writes), 32'd3);
        checkOutput("small_core3_idle", 32'(s_core3_seen), 32'd0);

        applyStimulus(16'hFFFE, 20, 1'b1, 1'b0, 1'b0);
        waitJob("jobB");
        checkOutput("rr_first_core", 32'(wr_nonce[0] < 4), 32'd1);
        for (int k = 0; k < 3; k++) begin
            checkOutput("rr_consecutive", 32'(wr_cycle[k+1] - wr_cycle[k]), 32'd1);
            checkOutput("rr_order", 32'(wr_nonce[k+1]), 32'((wr_nonce[k] + 1) % 4));
        end

        applyStimulus(16'h0200, 5, 1'b0, 1'b1, 1'b1);
        waitJob("jobC");
`ifdef BITCOIN_SCHED_MIN_TRACK_EN
        checkOutput("best_h0", best_h0, 32'h0000_0010);
        checkOutput("best_nonce", best_nonce, 32'd9);
`endif

        applyStimulus(16'h0300, 10, 1'b0, 1'b0, 1'b0);
        c = 0;
        while (job_writes < 5 && c < 2000) begin
            @(negedge clk);
            c++;
        end
        checkOutput("midrst_reached", 32'(job_writes >= 5), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst_done", 32'(done), 32'd0);
        checkOutput("midrst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("midrst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("midrst_mem_data", mem_write_data, 32'd0);
        checkOutput("midrst_core_start", 32'(core_start), 32'd0);
        checkOutput("midrst_core_nonce", 32'(core_nonce != 128'd0), 32'd0);
`ifdef BITCOIN_SCHED_MIN_TRACK_EN
        checkOutput("midrst_best_h0", best_h0, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        repeat (5) @(negedge clk);
        checkOutput("idle_no_dispatch", 32'(core_start), 32'd0);
        checkOutput("idle_no_done", 32'(done), 32'd0);

        applyStimulus(16'h0100, 70, 1'b0, 1'b0, 1'b0);
        waitJob("jobE");

        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
